// File: rtl/dircc_output_arbiter.sv
// Packet-granular round-robin merge of NUM_DEVICES Avalon-ST sources onto one link.
// Locks onto the granted source until its endofpacket beat is accepted.
module dircc_output_arbiter #(
  parameter int unsigned NUM_DEVICES      = 4,
  parameter int unsigned BITS_PER_SYMBOL  = 8,
  parameter int unsigned SYMBOLS_PER_BEAT = 4,
  localparam int unsigned DATA_WIDTH      = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT,
  localparam int unsigned EMPTY_WIDTH     = $clog2(SYMBOLS_PER_BEAT)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NUM_DEVICES*DATA_WIDTH-1:0]  in_data_i,
  input  logic [NUM_DEVICES*EMPTY_WIDTH-1:0] in_empty_i,
  input  logic [NUM_DEVICES-1:0]             in_startofpacket_i,
  input  logic [NUM_DEVICES-1:0]             in_endofpacket_i,
  input  logic [NUM_DEVICES-1:0]             in_valid_i,
  output logic [NUM_DEVICES-1:0]             in_ready_o,
  output logic [DATA_WIDTH-1:0]              out_data_o,
  output logic [EMPTY_WIDTH-1:0]             out_empty_o,
  output logic                               out_startofpacket_o,
  output logic                               out_endofpacket_o,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [NUM_DEVICES-1:0]             grant_o,
  output logic                               busy_o,
  output logic [31:0]                        packet_count_o,
  output logic                               framing_error_o
);

  localparam int unsigned IdxW = $clog2(NUM_DEVICES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DEVICES - 1);

  typedef enum logic {StIdle, StForward} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] sel_q, sel_d;
  logic [IdxW-1:0] last_grant_q, last_grant_d;
  logic [31:0]     packet_count_q, packet_count_d;
  logic            framing_error_q, framing_error_d;
  logic            first_beat_q, first_beat_d;

  logic [DATA_WIDTH-1:0]  data_arr  [NUM_DEVICES];
  logic [EMPTY_WIDTH-1:0] empty_arr [NUM_DEVICES];

  for (genvar g = 0; g < NUM_DEVICES; g++) begin : g_unpack
    assign data_arr[g]  = in_data_i[g*DATA_WIDTH +: DATA_WIDTH];
    assign empty_arr[g] = in_empty_i[g*EMPTY_WIDTH +: EMPTY_WIDTH];
  end

  // Search starts just after the last owner so every source waits at most N-1 packets.
  logic            req_found;
  logic [IdxW-1:0] req_idx;
  logic [IdxW-1:0] cand;

  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_DEVICES; k++) begin
      cand = IdxW'((32'(last_grant_q) + k) % NUM_DEVICES);
      if (!req_found && in_valid_i[cand]) begin
        req_found = 1'b1;
        req_idx   = cand;
      end
    end
  end

  logic accept;

  always_comb begin
    state_d             = state_q;
    sel_d               = sel_q;
    last_grant_d        = last_grant_q;
    packet_count_d      = packet_count_q;
    framing_error_d     = framing_error_q;
    first_beat_d        = first_beat_q;
    accept              = 1'b0;
    in_ready_o          = '0;
    grant_o             = '0;
    busy_o              = 1'b0;
    out_valid_o         = 1'b0;
    out_startofpacket_o = 1'b0;
    out_endofpacket_o   = 1'b0;
    out_data_o          = '0;
    out_empty_o         = '0;

    case (state_q)
      StIdle: begin
        if (req_found) begin
          sel_d        = req_idx;
          first_beat_d = 1'b1;
          state_d      = StForward;
        end
      end
      StForward: begin
        busy_o              = 1'b1;
        grant_o[sel_q]      = 1'b1;
        in_ready_o[sel_q]   = out_ready_i;
        out_valid_o         = in_valid_i[sel_q];
        out_startofpacket_o = in_startofpacket_i[sel_q];
        out_endofpacket_o   = in_endofpacket_i[sel_q];
        out_data_o          = data_arr[sel_q];
        out_empty_o         = empty_arr[sel_q];
        accept              = in_valid_i[sel_q] & out_ready_i;
        if (accept) begin
          first_beat_d = 1'b0;
          // sop must appear on the first beat and nowhere else
          if (first_beat_q != in_startofpacket_i[sel_q]) framing_error_d = 1'b1;
          if (in_endofpacket_i[sel_q]) begin
            last_grant_d   = sel_q;
            packet_count_d = packet_count_q + 32'd1;
            state_d        = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= StIdle;
      sel_q           <= '0;
      last_grant_q    <= LastIdx;
      packet_count_q  <= '0;
      framing_error_q <= 1'b0;
      first_beat_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      sel_q           <= sel_d;
      last_grant_q    <= last_grant_d;
      packet_count_q  <= packet_count_d;
      framing_error_q <= framing_error_d;
      first_beat_q    <= first_beat_d;
    end
  end

  assign packet_count_o  = packet_count_q;
  assign framing_error_o = framing_error_q;

endmodule

// File: tb/tb_dircc_output_arbiter.sv
// Bench for dircc_output_arbiter: directed packet scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level arbiter model.
module tb_dircc_output_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int EW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    vld = '0, sop = '0, eop = '0;
  logic [DW-1:0]   dat [N];
  logic [EW-1:0]   emp [N];
  logic [N*DW-1:0] in_data;
  logic [N*EW-1:0] in_empty;
  logic            out_ready = 1'b1;

  logic [N-1:0]  in_ready, grant;
  logic [DW-1:0] out_data;
  logic [EW-1:0] out_empty;
  logic          out_sop, out_eop, out_valid, busy, framing_error;
  logic [31:0]   packet_count;

  always_comb begin
    in_data  = '0;
    in_empty = '0;
    for (int i = 0; i < N; i++) begin
      in_data[i*DW +: DW]  = dat[i];
      in_empty[i*EW +: EW] = emp[i];
    end
  end

  dircc_output_arbiter #(
    .NUM_DEVICES     (N),
    .BITS_PER_SYMBOL (8),
    .SYMBOLS_PER_BEAT(4)
  ) u_dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .in_data_i          (in_data),
    .in_empty_i         (in_empty),
    .in_startofpacket_i (sop),
    .in_endofpacket_i   (eop),
    .in_valid_i         (vld),
    .in_ready_o         (in_ready),
    .out_data_o         (out_data),
    .out_empty_o        (out_empty),
    .out_startofpacket_o(out_sop),
    .out_endofpacket_o  (out_eop),
    .out_valid_o        (out_valid),
    .out_ready_i        (out_ready),
    .grant_o            (grant),
    .busy_o             (busy),
    .packet_count_o     (packet_count),
    .framing_error_o    (framing_error)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 when idle), last owner, counters.
  int          m_owner = -1;
  int          m_last  = N - 1;
  bit          m_first = 1'b0;
  logic [31:0] m_count = '0;
  bit          m_err   = 1'b0;

  // Requester closest after 'last' in circular order, or -1.
  function automatic int rr_pick(input int last, input logic [N-1:0] req);
    int best  = -1;
    int bestd = N;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        int d;
        d = (i - last - 1 + 2 * N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1;
      m_last  <= N - 1;
      m_first <= 1'b0;
      m_count <= '0;
      m_err   <= 1'b0;
    end else if (m_owner < 0) begin
      m_owner <= rr_pick(m_last, vld);
      m_first <= 1'b1;
    end else if (vld[m_owner] && out_ready) begin
      m_first <= 1'b0;
      if (m_first != sop[m_owner]) m_err <= 1'b1;
      if (eop[m_owner]) begin
        m_last  <= m_owner;
        m_count <= m_count + 32'd1;
        m_owner <= -1;
      end
    end
  end

  // Output monitor: accepted beats and grant sequence.
  logic [DW-1:0] out_log [$];
  int            gnt_log [$];
  logic [N-1:0]  prev_grant = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_grant", 64'(grant), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_sop_eop", 64'({out_sop, out_eop}), 64'd0);
    end else if (m_owner < 0) begin
      check("idle_out_valid", 64'(out_valid), 64'd0);
      check("idle_in_ready", 64'(in_ready), 64'd0);
      check("idle_grant", 64'(grant), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
    end else begin
      check("fwd_out_valid", 64'(out_valid), 64'(vld[m_owner]));
      check("fwd_in_ready", 64'(in_ready), 64'(out_ready) << m_owner);
      check("fwd_grant", 64'(grant), 64'd1 << m_owner);
      check("fwd_busy", 64'(busy), 64'd1);
      check("fwd_data", 64'(out_data), 64'(dat[m_owner]));
      check("fwd_empty", 64'(out_empty), 64'(emp[m_owner]));
      check("fwd_sop", 64'(out_sop), 64'(sop[m_owner]));
      check("fwd_eop", 64'(out_eop), 64'(eop[m_owner]));
    end
    check("packet_count", 64'(packet_count), 64'(m_count));
    check("framing_error", 64'(framing_error), 64'(m_err));
    if (rst_n && out_valid && out_ready) out_log.push_back(out_data);
    if (grant != '0 && prev_grant == '0) begin
      for (int i = 0; i < N; i++) if (grant[i]) gnt_log.push_back(i);
    end
    prev_grant <= grant;
  end

  // Automatic per-source packet generator.
  int a_len [N];
  int a_beat [N];
  int a_pkts [N];
  int a_serial [N];
  int a_pvalid = 100;
  int a_lmin = 1, a_lmax = 1;
  int a_badsop = 0;
  int rdy_mode = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic s, input logic e,
                       input logic [DW-1:0] d, input logic [EW-1:0] em);
    vld[i] = v;
    sop[i] = s;
    eop[i] = e;
    dat[i] = d;
    emp[i] = em;
  endtask

  task automatic auto_cycle();
    logic [N-1:0] hs;
    @(negedge clk);
    hs = vld & in_ready;
    @(posedge clk);
    #1;
    case (rdy_mode)
      1:       out_ready = ~out_ready;
      2:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b1;
    endcase
    for (int i = 0; i < N; i++) begin
      if (a_len[i] != 0 && hs[i]) begin
        a_beat[i]++;
        if (a_beat[i] == a_len[i]) begin
          a_len[i] = 0;
          a_serial[i]++;
        end
      end
      if (a_len[i] == 0 && a_pkts[i] > 0) begin
        a_pkts[i]--;
        a_len[i]  = int'($urandom_range(a_lmin, a_lmax));
        a_beat[i] = 0;
      end
      if (a_len[i] != 0) begin
        vld[i] = (int'($urandom_range(0, 99)) < a_pvalid);
        sop[i] = (a_beat[i] == 0) ^ (int'($urandom_range(0, 99)) < a_badsop);
        eop[i] = (a_beat[i] == a_len[i] - 1);
        dat[i] = {8'(i), 8'(a_serial[i]), 8'(a_beat[i]), 8'h5A};
        emp[i] = eop[i] ? EW'(i) : '0;
      end else begin
        vld[i] = 1'b0;
        sop[i] = 1'b0;
        eop[i] = 1'b0;
      end
    end
  endtask

  task automatic run_auto(input int max_cycles, output int used);
    bit done;
    used = 0;
    done = 1'b0;
    while (!done && used < max_cycles) begin
      auto_cycle();
      used++;
      done = !busy;
      for (int i = 0; i < N; i++) if (a_len[i] != 0 || a_pkts[i] != 0) done = 1'b0;
    end
    check("auto_drain_done", 64'(done), 64'd1);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    out_ready = 1'b1;
    rdy_mode  = 0;
    a_pvalid  = 100;
    a_badsop  = 0;
    for (int i = 0; i < N; i++) begin
      drive(i, 1'b0, 1'b0, 1'b0, '0, '0);
      a_len[i]    = 0;
      a_beat[i]   = 0;
      a_pkts[i]   = 0;
      a_serial[i] = 0;
    end
    #1;
    check("reset_packet_count", 64'(packet_count), 64'd0);
    check("reset_framing_error", 64'(framing_error), 64'd0);
    check("reset_grant", 64'(grant), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int used;
    int lb, gb;

    // Source 2 sends a 3-beat packet.
    do_reset();
    step();
    drive(2, 1'b1, 1'b1, 1'b0, 32'hA0, '0);
    @(negedge clk);
    check("t1_grant_before_edge", 64'(grant), 64'h0);
    step();
    @(negedge clk);
    check("t1_grant", 64'(grant), 64'h4);
    check("t1_data0", 64'(out_data), 64'hA0);
    step();
    drive(2, 1'b1, 1'b0, 1'b0, 32'hA1, '0);
    @(negedge clk);
    check("t1_data1", 64'(out_data), 64'hA1);
    step();
    drive(2, 1'b1, 1'b0, 1'b1, 32'hA2, '0);
    @(negedge clk);
    check("t1_data2", 64'(out_data), 64'hA2);
    check("t1_eop", 64'(out_eop), 64'd1);
    step();
    drive(2, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("t1_busy_after", 64'(busy), 64'd0);
    check("t1_count", 64'(packet_count), 64'd1);

    // All sources request 2-beat packets; five packets total.
    do_reset();
    a_lmin = 2;
    a_lmax = 2;
    a_pkts[0] = 2;
    a_pkts[1] = 1;
    a_pkts[2] = 1;
    a_pkts[3] = 1;
    gb = gnt_log.size();
    used = 0;
    while (packet_count != 32'd5 && used < 100) begin
      auto_cycle();
      used++;
    end
    check("t2_cycles_to_five", 64'(used), 64'd16);
    check("t2_count", 64'(packet_count), 64'd5);
    run_auto(50, used);
    check("t2_grants", 64'(gnt_log.size() - gb), 64'd5);
    if (gnt_log.size() - gb == 5) begin
      check("t2_order0", 64'(gnt_log[gb]), 64'd0);
      check("t2_order1", 64'(gnt_log[gb + 1]), 64'd1);
      check("t2_order2", 64'(gnt_log[gb + 2]), 64'd2);
      check("t2_order3", 64'(gnt_log[gb + 3]), 64'd3);
      check("t2_order4", 64'(gnt_log[gb + 4]), 64'd0);
    end

    // Source 1, 4 beats, toggling out_ready; source 3 requests mid-packet.
    do_reset();
    rdy_mode = 1;
    a_lmin = 4;
    a_lmax = 4;
    a_pkts[1] = 1;
    lb = out_log.size();
    gb = gnt_log.size();
    repeat (3) auto_cycle();
    a_lmin = 1;
    a_lmax = 1;
    a_pkts[3] = 1;
    run_auto(60, used);
    check("t3_beats", 64'(out_log.size() - lb), 64'd5);
    if (out_log.size() - lb == 5) begin
      check("t3_beat0", 64'(out_log[lb]), 64'h0100005A);
      check("t3_beat1", 64'(out_log[lb + 1]), 64'h0100015A);
      check("t3_beat2", 64'(out_log[lb + 2]), 64'h0100025A);
      check("t3_beat3", 64'(out_log[lb + 3]), 64'h0100035A);
      check("t3_beat4", 64'(out_log[lb + 4]), 64'h0300005A);
    end
    check("t3_grants", 64'(gnt_log.size() - gb), 64'd2);
    if (gnt_log.size() - gb == 2) begin
      check("t3_first_owner", 64'(gnt_log[gb]), 64'd1);
      check("t3_second_owner", 64'(gnt_log[gb + 1]), 64'd3);
    end

    // Single-beat packet on source 0 with empty = 2.
    do_reset();
    step();
    drive(0, 1'b1, 1'b1, 1'b1, 32'h55, 2'd2);
    step();
    @(negedge clk);
    check("t4_grant", 64'(grant), 64'h1);
    check("t4_empty", 64'(out_empty), 64'd2);
    check("t4_sop_eop", 64'({out_sop, out_eop}), 64'h3);
    step();
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("t4_idle_next", 64'(busy), 64'd0);
    check("t4_count", 64'(packet_count), 64'd1);

    // Missing sop on the first beat of source 0 makes framing_error sticky.
    step();
    drive(0, 1'b1, 1'b0, 1'b0, 32'h66, '0);
    step();
    step();
    drive(0, 1'b1, 1'b0, 1'b1, 32'h67, '0);
    @(negedge clk);
    check("t5_err_set", 64'(framing_error), 64'd1);
    step();
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("t5_err_after_pkt", 64'(framing_error), 64'd1);
    a_lmin = 3;
    a_lmax = 3;
    a_pkts[2] = 1;
    run_auto(30, used);
    check("t5_err_after_good", 64'(framing_error), 64'd1);
    check("t5_count", 64'(packet_count), 64'd3);

    // Reset during beat 2 of a 4-beat packet from source 1.
    step();
    drive(1, 1'b1, 1'b1, 1'b0, 32'hB0, '0);
    step();
    @(negedge clk);
    check("t6_grant_pre", 64'(grant), 64'h2);
    step();
    drive(1, 1'b1, 1'b0, 1'b0, 32'hB1, '0);
    step();
    drive(1, 1'b1, 1'b0, 1'b0, 32'hB2, '0);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_out_valid", 64'(out_valid), 64'd0);
    check("t6_grant", 64'(grant), 64'd0);
    check("t6_count", 64'(packet_count), 64'd0);
    check("t6_err_cleared", 64'(framing_error), 64'd0);
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
    step();
    step();
    rst_n = 1'b1;
    drive(0, 1'b1, 1'b1, 1'b1, 32'hC0, '0);
    drive(3, 1'b1, 1'b1, 1'b1, 32'hC3, '0);
    step();
    @(negedge clk);
    check("t6_first_grant", 64'(grant), 64'h1);
    step();
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("t6_bubble", 64'(grant), 64'h0);
    step();
    @(negedge clk);
    check("t6_second_grant", 64'(grant), 64'h8);
    step();
    drive(3, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("t6_count_after", 64'(packet_count), 64'd2);

    // Randomized traffic against the model.
    a_pvalid = 75;
    a_lmin   = 1;
    a_lmax   = 5;
    a_badsop = 5;
    rdy_mode = 2;
    for (int i = 0; i < N; i++) a_pkts[i] = 1000;
    repeat (3000) auto_cycle();
    for (int i = 0; i < N; i++) a_pkts[i] = 0;
    run_auto(500, used);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
